// File: rtl/reg_file_8x8.sv
// -----------------------------------------------------------------------------
// reg_file_8x8
//   General-purpose register file feeding the ALU operand buses. Eight 8-bit
//   signed registers, two combinational read ports, one synchronous write port.
//   Optional same-cycle write-to-read forwarding (BYPASS = 1).
//
// Ports
//   CLK          in   1           system clock, rising edge
//   RESET        in   1           asynchronous active-low reset
//   IN           in   DATA_WIDTH  write data (ALU result)
//   INADDRESS    in   ADDR_WIDTH  write register index
//   WRITE        in   1           write enable, sampled at rising CLK
//   OUT1ADDRESS  in   ADDR_WIDTH  read port 1 index
//   OUT2ADDRESS  in   ADDR_WIDTH  read port 2 index
//   OUT1         out  DATA_WIDTH  read port 1 data (ALU operand 1)
//   OUT2         out  DATA_WIDTH  read port 2 data (ALU operand 2)
//   WRITE_ACK    out  1           high for the cycle after a committed write
//   WRITE_COUNT  out  8           committed-write counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module reg_file_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  WRITE_ACK,
    output logic [7:0]            WRITE_COUNT
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    // Registers are held in flops (not block RAM): they need an asynchronous
    // clear and two combinational read ports.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_wen;
    ack_state_t            r_state;
    ack_state_t            w_state_next;
    logic [7:0]            r_count;

    // One-hot write-enable decode.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wdec
            assign w_wen[gi] = WRITE && (INADDRESS == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= IN;
                end
            end
        end
    end

    // Ack machine: state simply follows WRITE sampled at each edge, so
    // back-to-back writes keep WRITE_ACK high.
    always_comb begin
        w_state_next = ST_IDLE;
        if (WRITE) begin
            w_state_next = ST_ACK;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (WRITE) begin
                r_count <= r_count + 8'd1;   // natural 8-bit wrap
            end
        end
    end

    assign WRITE_ACK   = (r_state == ST_ACK);
    assign WRITE_COUNT = r_count;

    // Read ports. Each port forwards independently when enabled.
    logic [ADDR_WIDTH-1:0] w_rd_addr [2];
    logic [DATA_WIDTH-1:0] w_rd_data [2];

    assign w_rd_addr[0] = OUT1ADDRESS;
    assign w_rd_addr[1] = OUT2ADDRESS;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            if (BYPASS != 0) begin : g_fwd
                assign w_rd_data[gi] = (WRITE && (w_rd_addr[gi] == INADDRESS))
                                       ? IN : r_regs[w_rd_addr[gi]];
            end else begin : g_nofwd
                assign w_rd_data[gi] = r_regs[w_rd_addr[gi]];
            end
        end
    endgenerate

    assign OUT1 = w_rd_data[0];
    assign OUT2 = w_rd_data[1];

endmodule

// File: tb/tb_reg_file_8x8.sv
// -----------------------------------------------------------------------------
// tb_reg_file_8x8
//   Directed bench for reg_file_8x8. Two instances share all inputs: u_dut0
//   without forwarding and u_dut1 with forwarding. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_reg_file_8x8;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [2:0] in_addr;
    logic       write;
    logic [2:0] out1_addr;
    logic [2:0] out2_addr;

    logic [7:0] out1_0, out2_0, count_0;
    logic       ack_0;
    logic [7:0] out1_1, out2_1, count_1;
    logic       ack_1;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file_8x8 #(.BYPASS(0)) u_dut0 (
        .CLK(clk), .RESET(rst_n), .IN(in_data), .INADDRESS(in_addr),
        .WRITE(write), .OUT1ADDRESS(out1_addr), .OUT2ADDRESS(out2_addr),
        .OUT1(out1_0), .OUT2(out2_0), .WRITE_ACK(ack_0), .WRITE_COUNT(count_0)
    );

    reg_file_8x8 #(.BYPASS(1)) u_dut1 (
        .CLK(clk), .RESET(rst_n), .IN(in_data), .INADDRESS(in_addr),
        .WRITE(write), .OUT1ADDRESS(out1_addr), .OUT2ADDRESS(out2_addr),
        .OUT1(out1_1), .OUT2(out2_1), .WRITE_ACK(ack_1), .WRITE_COUNT(count_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Single write committed at the next rising edge; WRITE dropped after it.
    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        in_addr = addr;
        in_data = data;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        $display("write r%0d <= 0x%02h  count=%0d", addr, data, count_0);
    endtask

    task automatic read_pair(input logic [2:0] a1, input logic [2:0] a2,
                             input logic [7:0] e1, input logic [7:0] e2);
        out1_addr = a1;
        out2_addr = a2;
        #1;
        check_eq("read_out1", out1_0, e1);
        check_eq("read_out2", out2_0, e2);
        $display("read  r%0d=0x%02h r%0d=0x%02h", a1, out1_0, a2, out2_0);
    endtask

    initial begin
        logic [7:0] wdata [8];
        wdata[0] = 8'd25; wdata[1] = 8'd3;  wdata[2] = 8'd1;  wdata[3] = 8'd8;
        wdata[4] = 8'd2;  wdata[5] = 8'hFB; wdata[6] = 8'd6;  wdata[7] = 8'hFE;

        rst_n = 1'b0; in_data = 8'h00; in_addr = 3'd0; write = 1'b0;
        out1_addr = 3'd0; out2_addr = 3'd0;

        // Writes attempted while reset is held are lost.
        @(negedge clk);
        in_addr = 3'd0; in_data = 8'h55; write = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_write_lost", out1_0, 8'h00);
        check_eq("rst_ack",        8'(ack_0), 8'h00);
        check_eq("rst_count",      count_0, 8'h00);
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;

        // Reset sweep: write r3 then reset mid-cycle.
        out1_addr = 3'd3;
        do_write(3'd3, 8'h19);
        check_eq("sweep_written", out1_0, 8'h19);
        check_eq("sweep_ack_hi",  8'(ack_0), 8'h01);
        check_eq("sweep_count1",  count_0, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("sweep_out1_clr", out1_0, 8'h00);
        check_eq("sweep_ack_clr",  8'(ack_0), 8'h00);
        check_eq("sweep_cnt_clr",  count_0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Write all registers, then read pairs.
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), wdata[i]);
        end
        check_eq("all_count8", count_0, 8'd8);
        read_pair(3'd0, 3'd1, 8'd25, 8'd3);
        read_pair(3'd4, 3'd5, 8'd2,  8'hFB);
        read_pair(3'd6, 3'd7, 8'd6,  8'hFE);
        read_pair(3'd3, 3'd3, 8'd8,  8'd8);

        // Same-address read/write; dut1 forwards, dut0 does not.
        @(negedge clk);
        out1_addr = 3'd2; out2_addr = 3'd4;
        in_addr = 3'd2; in_data = 8'h08; write = 1'b1;
        #1;
        check_eq("nobyp_before", out1_0, 8'h01);
        check_eq("byp_before",   out1_1, 8'h08);
        check_eq("byp_out2",     out2_1, 8'h02);
        check_eq("nobyp_out2",   out2_0, 8'h02);
        @(posedge clk); #1;
        write = 1'b0;
        check_eq("nobyp_after",  out1_0, 8'h08);
        check_eq("byp_after",    out1_1, 8'h08);
        check_eq("same_ack_hi",  8'(ack_0), 8'h01);
        check_eq("same_count9",  count_0, 8'd9);
        @(posedge clk); #1;
        check_eq("same_ack_lo",  8'(ack_0), 8'h00);
        $display("same-address write r2 <= 0x08 done");

        // Write disabled for three edges.
        @(negedge clk);
        out1_addr = 3'd5; in_addr = 3'd5; in_data = 8'hAA; write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("wdis_r5",     out1_0, 8'hFB);
        check_eq("wdis_r5_byp", out1_1, 8'hFB);
        check_eq("wdis_ack",    8'(ack_0), 8'h00);
        check_eq("wdis_count",  count_0, 8'd9);
        $display("write-disabled r5 kept 0x%02h", out1_0);

        // Counter wrap: reset, then 256 back-to-back writes.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("wrap_start", count_0, 8'd0);
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            write = 1'b1;
            in_addr = 3'(k - 1);
            in_data = 8'(k - 1);
            @(posedge clk); #1;
            check_eq("wrap_ack", 8'(ack_0), 8'h01);
            if (k == 255) check_eq("wrap_cnt255", count_0, 8'd255);
            if (k == 256) check_eq("wrap_cnt0",   count_0, 8'd0);
        end
        write = 1'b0;
        $display("256 back-to-back writes done, count=%0d", count_0);
        read_pair(3'd0, 3'd7, 8'd248, 8'd255);
        check_eq("wrap_count_dut1", count_1, 8'd0);
        @(posedge clk); #1;
        check_eq("wrap_ack_drop", 8'(ack_0), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
- General-purpose register file sitting directly upstream of the ALU.
- Two combinational read ports drive the ALU operand buses (DATA1/DATA2 path feeding the And/Add/Or/Forward units).
- One synchronous write port accepts the ALU result for writeback.
- Holds the processor's architectural register state: 8 registers x 8 bits, signed two's-complement data.

Parameters:
- DATA_WIDTH, 8, width of each register and of all data ports.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 3, width of each register address port.
- BYPASS, 0, 1 = write-to-read forwarding on a same-cycle address match; 0 = reads return stored contents only.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset; clears all registers when low.
- IN  input  DATA_WIDTH  write data (ALU result).
- INADDRESS  input  ADDR_WIDTH  write register index.
- WRITE  input  1  write enable, sampled at the rising CLK edge.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 register index.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 register index.
- OUT1  output  DATA_WIDTH  read port 1 data (ALU operand 1).
- OUT2  output  DATA_WIDTH  read port 2 data (ALU operand 2).
- WRITE_ACK  output  1  one-cycle pulse: a write was committed at the preceding edge.
- WRITE_COUNT  output  8  count of committed writes, wraps 255 -> 0.

Behaviour:
- Reset
  - RESET low immediately clears all registers, WRITE_ACK and WRITE_COUNT to 0, independent of CLK.
  - OUT1/OUT2 therefore read 0 during and after reset.
  - While RESET is low, rising edges have no effect, even with WRITE = 1.
  - Deassertion is synchronised externally; the first active edge is the first rising CLK edge with RESET high.
- Write
  - At a rising edge with RESET high and WRITE = 1: reg[INADDRESS] <= IN.
  - On that same edge: WRITE_ACK <= 1 and WRITE_COUNT <= WRITE_COUNT + 1 (mod 256).
  - At an edge with WRITE = 0: no register changes and WRITE_ACK <= 0.
  - Write latency: 1 edge; the new value is visible on the read ports immediately after that edge.
- Read
  - Purely combinational, no clock involved.
  - OUT1 = reg[OUT1ADDRESS] and OUT2 = reg[OUT2ADDRESS].
  - Both ports may address the same register and return identical values.
- BYPASS = 1
  - If WRITE = 1 and OUTnADDRESS == INADDRESS, OUTn = IN combinationally before the edge.
  - Forwarding is evaluated per port independently.
- BYPASS = 0
  - OUTn shows the old value until the edge.
- Simultaneous read and write to the same address (BYPASS = 0)
  - Before the edge: old data.
  - After the edge: new data.
  - No glitch other than the edge-driven change.
- Write during reset assertion: the write is lost; WRITE_ACK stays 0.
- Reset mid-operation: reset asserted one cycle after a write clears the written register and WRITE_ACK asynchronously.
- Width rules
  - Data is stored bit-exact; no sign extension or truncation.
  - Addresses are always in range, since NUM_REGS = 2**ADDR_WIDTH.
- State: one implicit two-state ack machine, IDLE (WRITE_ACK = 0) and ACK (WRITE_ACK = 1).
  - Any state -> ACK on an edge with WRITE = 1.
  - Any state -> IDLE on an edge with WRITE = 0.
  - Back-to-back writes hold WRITE_ACK high continuously.
- Unknowns: X or Z on WRITE after reset is a bench error; no defined behaviour is required for that case.

Test Plan:
- Reset sweep
  - Stimulus: write 8'h19 to r3, then pull RESET low mid-cycle.
  - Required: OUT1 (addr 3) = 0 before the next edge; WRITE_ACK = 0; WRITE_COUNT = 0.
- Write/read all
  - Stimulus: write r0..r7 = 25, 3, 1, 8, 2, -5 (8'hFB), 6, -2 (8'hFE); read pairs (0,1), (4,5), (6,7).
  - Required: OUT1/OUT2 = 25/3, 2/-5, 6/-2; WRITE_COUNT = 8.
- Same-address read/write (BYPASS = 0)
  - Stimulus: r2 = 8'h01; with OUT1ADDRESS = 2, write 8'h08 to r2.
  - Required: OUT1 = 8'h01 before the edge and 8'h08 after; WRITE_ACK high for exactly one cycle.
- Forwarding (BYPASS = 1)
  - Stimulus: same stimulus as the previous scenario.
  - Required: OUT1 = 8'h08 as soon as IN/WRITE settle, before the edge; OUT2 on a different address unaffected.
- Write disabled
  - Stimulus: WRITE = 0, IN = 8'hAA, INADDRESS = 5 for 3 edges.
  - Required: r5 unchanged; WRITE_ACK = 0; WRITE_COUNT unchanged.
- Counter wrap and back-to-back writes
  - Stimulus: 256 consecutive writes with WRITE held high.
  - Required: WRITE_ACK high throughout; WRITE_COUNT returns to 0 after the 256th edge.
